// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core on CLK_REF: turns the divider's 1 Hz / 2 Hz square
// waves into single-cycle ticks and runs a PAUSED / RUN / ADJUST controller.
module stopwatch_counter #(
  parameter int MAX_MIN = 59
) (
  input  logic       CLK_REF,
  input  logic       CLK_RES,
  input  logic       CLK_1HZ,
  input  logic       CLK_2HZ,
  input  logic       PAUSE_PULSE,
  input  logic       CLEAR,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       RUNNING,
  output logic       BLANK_MIN,
  output logic       BLANK_SEC,
  output logic       WRAP
);

  typedef enum logic [1:0] {
    S_PAUSED = 2'd0,
    S_RUN    = 2'd1,
    S_ADJUST = 2'd2
  } state_t;

  localparam logic [6:0] MIN_LIMIT = 7'(MAX_MIN);
  localparam logic [6:0] SEC_LIMIT = 7'd59;

  // Returns {tens, ones} advanced by one, wrapping to 00 once the limit is hit.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                         input logic [3:0] ones,
                                         input logic [6:0] limit);
    logic [6:0] value;
    value = {3'b000, tens} * 7'd10 + {3'b000, ones};
    if (value >= limit)   return 8'h00;
    else if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    else                  return {tens, ones + 4'd1};
  endfunction

  function automatic logic at_limit(input logic [3:0] tens,
                                    input logic [3:0] ones,
                                    input logic [6:0] limit);
    return ({3'b000, tens} * 7'd10 + {3'b000, ones}) >= limit;
  endfunction

  state_t     state_q, state_d;
  logic       armed_q;
  logic       prev_1hz_q, prev_2hz_q;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       wrap_q, wrap_d;
  logic       blank_min_q, blank_min_d;
  logic       blank_sec_q, blank_sec_d;

  logic       tick1, tick2;
  logic       sec_max, min_max;
  logic [7:0] sec_next, min_next;

  // Until the prev registers have seen one real sample, a difference is not an edge.
  assign tick1 = armed_q && (CLK_1HZ != prev_1hz_q);
  assign tick2 = armed_q && (CLK_2HZ != prev_2hz_q);

  assign sec_max  = at_limit(sec_tens_q, sec_ones_q, SEC_LIMIT);
  assign min_max  = at_limit(min_tens_q, min_ones_q, MIN_LIMIT);
  assign sec_next = bcd_inc(sec_tens_q, sec_ones_q, SEC_LIMIT);
  assign min_next = bcd_inc(min_tens_q, min_ones_q, MIN_LIMIT);

  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    // NOTE: every register here uses <= so all of them sample the same pre-edge values.
    if (CLK_RES) begin
      armed_q     <= 1'b0;
      prev_1hz_q  <= 1'b0;
      prev_2hz_q  <= 1'b0;
      state_q     <= S_PAUSED;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
      wrap_q      <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      armed_q     <= 1'b1;
      prev_1hz_q  <= CLK_1HZ;
      prev_2hz_q  <= CLK_2HZ;
      state_q     <= state_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      wrap_q      <= wrap_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through this block can infer a latch.
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    wrap_d     = 1'b0;

    blank_min_d = (state_q == S_ADJUST) && !SEL && CLK_2HZ;
    blank_sec_d = (state_q == S_ADJUST) &&  SEL && CLK_2HZ;

    if (CLEAR) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (state_q == S_RUN && tick1) begin
      {sec_tens_d, sec_ones_d} = sec_next;
      if (sec_max) begin
        {min_tens_d, min_ones_d} = min_next;
        wrap_d = min_max;
      end
    end else if (state_q == S_ADJUST && tick2) begin
      // Adjust rolls each field on its own; seconds never carry into minutes.
      if (SEL) {sec_tens_d, sec_ones_d} = sec_next;
      else     {min_tens_d, min_ones_d} = min_next;
    end

    case (state_q)
      S_PAUSED: begin
        if (ADJ)              state_d = S_ADJUST;
        else if (PAUSE_PULSE) state_d = S_RUN;
      end
      S_RUN: begin
        if (ADJ)              state_d = S_ADJUST;
        else if (PAUSE_PULSE) state_d = S_PAUSED;
      end
      S_ADJUST: begin
        if (!ADJ)             state_d = S_PAUSED;
      end
      default:                state_d = S_PAUSED;
    endcase
  end

  assign MIN_TENS  = min_tens_q;
  assign MIN_ONES  = min_ones_q;
  assign SEC_TENS  = sec_tens_q;
  assign SEC_ONES  = sec_ones_q;
  assign RUNNING   = (state_q == S_RUN);
  assign BLANK_MIN = blank_min_q;
  assign BLANK_SEC = blank_sec_q;
  assign WRAP      = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus a random
// phase, all compared every cycle against a seconds-arithmetic reference model.
module tb_stopwatch_counter;

  localparam int MAX_MIN = 59;
  localparam int P_PAUSED = 0, P_RUN = 1, P_ADJ = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic c1 = 1'b0, c2 = 1'b0, pause = 1'b0, clear = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, blank_min, blank_sec, wrap;

  int checks = 0, errors = 0, wrap_cnt = 0;

  stopwatch_counter #(.MAX_MIN(MAX_MIN)) dut (
    .CLK_REF(clk), .CLK_RES(rst), .CLK_1HZ(c1), .CLK_2HZ(c2),
    .PAUSE_PULSE(pause), .CLEAR(clear), .ADJ(adj), .SEL(sel),
    .MIN_TENS(min_tens), .MIN_ONES(min_ones), .SEC_TENS(sec_tens), .SEC_ONES(sec_ones),
    .RUNNING(running), .BLANK_MIN(blank_min), .BLANK_SEC(blank_sec), .WRAP(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as plain minute/second integers, state as a mode number.
  int m_min, m_sec, m_state;
  bit m_armed, m_p1, m_p2, m_wrap, m_bmin, m_bsec;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_min = 0; m_sec = 0; m_state = P_PAUSED;
      m_armed = 0; m_p1 = 0; m_p2 = 0; m_wrap = 0; m_bmin = 0; m_bsec = 0;
    end else begin
      bit t1, t2;
      int total;
      t1 = m_armed && (c1 != m_p1);
      t2 = m_armed && (c2 != m_p2);
      m_armed = 1; m_p1 = c1; m_p2 = c2;
      m_bmin = (m_state == P_ADJ) && !sel && c2;
      m_bsec = (m_state == P_ADJ) &&  sel && c2;
      m_wrap = 0;
      if (clear) begin
        m_min = 0; m_sec = 0;
      end else if (m_state == P_RUN && t1) begin
        total = m_min * 60 + m_sec + 1;
        if (total == (MAX_MIN + 1) * 60) begin total = 0; m_wrap = 1; end
        m_min = total / 60; m_sec = total % 60;
      end else if (m_state == P_ADJ && t2) begin
        if (sel) m_sec = (m_sec + 1) % 60;
        else     m_min = (m_min + 1) % (MAX_MIN + 1);
      end
      if (adj)                    m_state = P_ADJ;
      else if (m_state == P_ADJ)  m_state = P_PAUSED;
      else if (pause)             m_state = (m_state == P_RUN) ? P_PAUSED : P_RUN;
    end
  end

  function automatic logic [15:0] bcd_time(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(negedge clk) begin
    check("digits", {min_tens, min_ones, sec_tens, sec_ones}, bcd_time(m_min, m_sec));
    check("running", running, m_state == P_RUN);
    check("blank_min", blank_min, m_bmin);
    check("blank_sec", blank_sec, m_bsec);
    check("wrap", wrap, m_wrap);
    if (wrap) wrap_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; step(1); pause = 1'b0;
  endtask

  task automatic toggle_1hz(input int n);
    for (int i = 0; i < n; i++) begin c1 = ~c1; step(2); end
  endtask

  // Walks the model's time to mm:ss through ADJUST; leaves ADJ high and SEL=1.
  task automatic adjust_to(input int mm, input int ss);
    adj = 1'b1; sel = 1'b0; step(1);
    for (int i = 0; i < 200 && m_min != mm; i++) begin c2 = ~c2; step(2); end
    sel = 1'b1; step(1);
    for (int i = 0; i < 200 && m_sec != ss; i++) begin c2 = ~c2; step(2); end
    check("adjust_reached", bcd_time(m_min, m_sec), bcd_time(mm, ss));
  endtask

  initial begin
    int need;
    step(2);
    rst = 1'b0;
    step(1);
    check("reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("reset_running", running, 1'b0);

    // 1: 61 count ticks from 00:00
    pulse_pause();
    wrap_cnt = 0;
    toggle_1hz(61);
    check("t1_time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0101);
    check("t1_running", running, 1'b1);
    check("t1_no_wrap", wrap_cnt, 0);

    // 2: 59:58 + 2 ticks wraps once
    adjust_to(59, 58);
    adj = 1'b0; step(1);
    pulse_pause();
    wrap_cnt = 0;
    c1 = ~c1; step(2);
    check("t2_5959", {min_tens, min_ones, sec_tens, sec_ones}, 16'h5959);
    c1 = ~c1; step(1);
    check("t2_zero", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("t2_wrap_now", wrap, 1'b1);
    check("t2_min_tens", min_tens, 4'd0);
    step(3);
    check("t2_wrap_once", wrap_cnt, 1);

    // 3: seconds adjust from 00:10 by 55 wraps to 00:05, blank follows CLK_2HZ
    toggle_1hz(10);
    check("t3_0010", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0010);
    adj = 1'b1; sel = 1'b1; step(1);
    for (int i = 0; i < 55; i++) begin
      c2 = ~c2; step(1);
      check("t3_blank_sec", blank_sec, c2);
      check("t3_blank_min", blank_min, 1'b0);
      step(1);
    end
    check("t3_0005", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0005);
    adj = 1'b0; step(1);
    check("t3_blank_off", blank_sec, 1'b0);

    // 4: CLEAR beats a same-cycle count tick at 12:34
    adjust_to(12, 34);
    adj = 1'b0; step(1);
    pulse_pause();
    clear = 1'b1; c1 = ~c1; step(1); clear = 1'b0;
    check("t4_cleared", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("t4_no_wrap", wrap, 1'b0);
    check("t4_still_run", running, 1'b1);
    step(2);

    // 5: CLK_1HZ high through reset release does not tick
    c1 = 1'b1; rst = 1'b1; step(2); rst = 1'b0;
    step(1);
    pulse_pause();
    step(3);
    check("t5_no_tick", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("t5_running", running, 1'b1);
    c1 = 1'b0; step(1);
    check("t5_first_tick", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0001);

    // 6: async reset mid-cycle in ADJUST at 07:07 with the seconds field blanked
    need = ((7 - m_min + MAX_MIN + 1) % (MAX_MIN + 1)) + ((7 - m_sec + 60) % 60);
    if ((c2 ^ need[0]) == 1'b0) begin c2 = ~c2; step(2); end
    adjust_to(7, 7);
    step(1);
    check("t6_0707", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0707);
    check("t6_blank_pre", blank_sec, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("t6_async_running", running, 1'b0);
    check("t6_async_blank", {blank_min, blank_sec}, 2'b00);
    step(2);
    rst = 1'b0; adj = 1'b0;
    step(2);

    // Random phase near the wrap point
    adjust_to(59, 50);
    adj = 1'b0; step(1);
    pulse_pause();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      pause = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 9) == 0)  sel = ~sel;
      if ($urandom_range(0, 2) == 0)  c1 = ~c1;
      if ($urandom_range(0, 3) == 0)  c2 = ~c2;
      rst = (cyc == 900);
      step(1);
    end
    pause = 1'b0; clear = 1'b0; rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
